// File: rtl/ast_array_feeder_v_pkg.sv
// Shared constants for the systolic-array feeder and its neighbouring stages:
// default operand width, array dimension, FSM state encoding and stream length.
package ast_array_feeder_v_pkg;

    localparam int DEF_DATAWIDTH = 16;
    localparam int DEF_SIZE      = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_FLUSH  = 2'd3;

    // Diagonal skew needs every row/column offset 0..2*(N-1) plus N-1 more elements.
    function automatic int stream_len(input int size);
        return 3 * size - 2;
    endfunction

    localparam int DEF_STREAM_LEN = stream_len(DEF_SIZE);

endpackage

// File: rtl/ast_array_feeder_v_skew.sv
// Picks the skewed operand for one array edge input: element k = t - IDX of
// row IDX of A (COL = 0) or of column IDX of B (COL = 1), or zero outside the band.
module ast_skew_select_v #(
    parameter int DW  = 16,
    parameter int N   = 4,
    parameter int IDX = 0,
    parameter int COL = 0,
    parameter int TW  = 4
) (
    input  logic [TW-1:0]       t,
    input  logic [N*N*DW-1:0]   mat,
    output logic [DW-1:0]       operand
);

    always_comb begin
        operand = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(t) == IDX + k) begin
                operand = mat[((COL != 0) ? (k * N + IDX) : (IDX * N + k)) * DW +: DW];
            end
        end
    end

endmodule

// File: rtl/ast_array_feeder_v.sv
// Holds operand matrices A and B and streams them diagonally skewed into an
// N x N MAC array, with clear and flush phases around the stream.
module ast_array_feeder_v
    import ast_array_feeder_v_pkg::*;
#(
    parameter int DATAWIDTH    = DEF_DATAWIDTH,
    parameter int SIZE         = DEF_SIZE,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [$clog2(SIZE)-1:0]   wr_row,
    input  logic [$clog2(SIZE)-1:0]   wr_col,
    input  logic [DATAWIDTH-1:0]      wr_data,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [DATAWIDTH-1:0]      a_feed_0,
    output logic [DATAWIDTH-1:0]      a_feed_1,
    output logic [DATAWIDTH-1:0]      a_feed_2,
    output logic [DATAWIDTH-1:0]      a_feed_3,
    output logic [DATAWIDTH-1:0]      b_feed_0,
    output logic [DATAWIDTH-1:0]      b_feed_1,
    output logic [DATAWIDTH-1:0]      b_feed_2,
    output logic [DATAWIDTH-1:0]      b_feed_3,
    output logic                      load_en,
    output logic                      mult_en,
    output logic                      acc_en
);

    localparam int SLEN = stream_len(SIZE);
    localparam int TW   = $clog2(SLEN);
    localparam int FW   = $clog2(FLUSH_CYCLES + 1);
    localparam int MW   = SIZE * SIZE * DATAWIDTH;

    logic [1:0]           state_q, state_d;
    logic [TW-1:0]        t_q, t_d;
    logic [FW-1:0]        fl_q, fl_d;
    logic [MW-1:0]        a_mat_q, a_mat_d;
    logic [MW-1:0]        b_mat_q, b_mat_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_q, load_d;
    logic                 mac_q, mac_d;
    logic [DATAWIDTH-1:0] a_sel [SIZE];
    logic [DATAWIDTH-1:0] b_sel [SIZE];
    logic [DATAWIDTH-1:0] a_feed_d [SIZE];
    logic [DATAWIDTH-1:0] b_feed_d [SIZE];
    logic [DATAWIDTH-1:0] a_feed_q [SIZE];
    logic [DATAWIDTH-1:0] b_feed_q [SIZE];

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        fl_d    = fl_q;
        a_mat_d = a_mat_q;
        b_mat_d = b_mat_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A write in the start cycle commits before the pass reads the matrices.
                if (wr_en) begin
                    for (int r = 0; r < SIZE; r++) begin
                        for (int c = 0; c < SIZE; c++) begin
                            if (int'(wr_row) == r && int'(wr_col) == c) begin
                                if (wr_sel) b_mat_d[(r * SIZE + c) * DATAWIDTH +: DATAWIDTH] = wr_data;
                                else        a_mat_d[(r * SIZE + c) * DATAWIDTH +: DATAWIDTH] = wr_data;
                            end
                        end
                    end
                end
                if (start) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
                t_d     = '0;
            end
            ST_STREAM: begin
                if (t_q == TW'(SLEN - 1)) begin
                    state_d = ST_FLUSH;
                    t_d     = '0;
                    fl_d    = '0;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            ST_FLUSH: begin
                if (fl_q == FW'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    fl_d = fl_q + FW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        load_d = (state_d == ST_CLEAR);
        mac_d  = (state_d == ST_STREAM) || (state_d == ST_FLUSH);
    end

    // Outputs are registered from the next state, so they track the state just entered.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_feed
            ast_skew_select_v #(.DW(DATAWIDTH), .N(SIZE), .IDX(gi), .COL(0), .TW(TW)) u_a_sel (
                .t(t_d), .mat(a_mat_q), .operand(a_sel[gi])
            );
            ast_skew_select_v #(.DW(DATAWIDTH), .N(SIZE), .IDX(gi), .COL(1), .TW(TW)) u_b_sel (
                .t(t_d), .mat(b_mat_q), .operand(b_sel[gi])
            );
            assign a_feed_d[gi] = (state_d == ST_STREAM) ? a_sel[gi] : '0;
            assign b_feed_d[gi] = (state_d == ST_STREAM) ? b_sel[gi] : '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            fl_q    <= '0;
            a_mat_q <= '0;
            b_mat_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            mac_q   <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                a_feed_q[i] <= '0;
                b_feed_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            fl_q    <= fl_d;
            a_mat_q <= a_mat_d;
            b_mat_q <= b_mat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            load_q  <= load_d;
            mac_q   <= mac_d;
            for (int i = 0; i < SIZE; i++) begin
                a_feed_q[i] <= a_feed_d[i];
                b_feed_q[i] <= b_feed_d[i];
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign load_en  = load_q;
    assign mult_en  = mac_q;
    assign acc_en   = mac_q;
    assign a_feed_0 = a_feed_q[0];
    assign a_feed_1 = a_feed_q[1];
    assign a_feed_2 = a_feed_q[2];
    assign a_feed_3 = a_feed_q[3];
    assign b_feed_0 = b_feed_q[0];
    assign b_feed_1 = b_feed_q[1];
    assign b_feed_2 = b_feed_q[2];
    assign b_feed_3 = b_feed_q[3];

endmodule

// File: tb/tb_ast_array_feeder_v.sv
// Bench for ast_array_feeder_v: cycle-schedule reference model of the pass plus
// a behavioural 4x4 MAC array whose results are compared to a plain A x B product.
module tb_ast_array_feeder_v;

    localparam int N    = 4;
    localparam int F    = 2;
    localparam int SLEN = 3 * N - 2;
    localparam int LAST = 3 * N - 1 + F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [1:0]  wr_row = '0;
    logic [1:0]  wr_col = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        busy, done, load_en, mult_en, acc_en;
    logic [15:0] a_feed_0, a_feed_1, a_feed_2, a_feed_3;
    logic [15:0] b_feed_0, b_feed_1, b_feed_2, b_feed_3;
    logic [15:0] af [N];
    logic [15:0] bf [N];

    assign af[0] = a_feed_0; assign af[1] = a_feed_1;
    assign af[2] = a_feed_2; assign af[3] = a_feed_3;
    assign bf[0] = b_feed_0; assign bf[1] = b_feed_1;
    assign bf[2] = b_feed_2; assign bf[3] = b_feed_3;

    ast_array_feeder_v #(.DATAWIDTH(16), .SIZE(N), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .start(start),
        .busy(busy), .done(done),
        .a_feed_0(a_feed_0), .a_feed_1(a_feed_1), .a_feed_2(a_feed_2), .a_feed_3(a_feed_3),
        .b_feed_0(b_feed_0), .b_feed_1(b_feed_1), .b_feed_2(b_feed_2), .b_feed_3(b_feed_3),
        .load_en(load_en), .mult_en(mult_en), .acc_en(acc_en)
    );

    always #5 clk = ~clk;

    int unsigned vecs = 0;
    int unsigned errs = 0;

    // Model: n = busy-cycle number of the pass (0 = idle), md = done expected.
    int unsigned ma [N][N];
    int unsigned mb [N][N];
    int          n  = 0;
    bit          md = 1'b0;
    int unsigned ha [16][N];
    int unsigned hb [16][N];
    int          hlen = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        vecs++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned exp_a(input int i);
        int k;
        if (n < 2 || n > SLEN + 1) return 0;
        k = (n - 2) - i;
        return (k >= 0 && k < N) ? ma[i][k] : 0;
    endfunction

    function automatic int unsigned exp_b(input int j);
        int k;
        if (n < 2 || n > SLEN + 1) return 0;
        k = (n - 2) - j;
        return (k >= 0 && k < N) ? mb[k][j] : 0;
    endfunction

    // PE(i,j) sees row operand delayed by j and column operand delayed by i.
    task automatic check_mac();
        int unsigned acc, ref_v;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                ref_v = 0;
                for (int c = 0; c < hlen; c++)
                    if (c >= i && c >= j) acc += ha[c - j][i] * hb[c - i][j];
                for (int k = 0; k < N; k++) ref_v += ma[i][k] * mb[k][j];
                chk($sformatf("mac_c%0d%0d", i, j), acc & 32'hFFFF, ref_v & 32'hFFFF);
            end
        end
    endtask

    task automatic check_all();
        chk("busy", busy, (n != 0));
        chk("done", done, md);
        chk("load_en", load_en, (n == 1));
        chk("mult_en", mult_en, (n >= 2));
        chk("acc_en", acc_en, (n >= 2));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("a_feed_%0d", i), af[i], exp_a(i));
            chk($sformatf("b_feed_%0d", i), bf[i], exp_b(i));
        end
        if (n == 1) hlen = 0;
        else if (n >= 2) begin
            for (int i = 0; i < N; i++) begin
                ha[hlen][i] = af[i];
                hb[hlen][i] = bf[i];
            end
            hlen++;
        end
        if (md) check_mac();
    endtask

    // Called at a falling edge: check, drive, advance the model across the next rising edge.
    task automatic step(input bit we, input bit sel, input int r, input int c,
                        input int unsigned d, input bit st);
        check_all();
        wr_en   = we;
        wr_sel  = sel;
        wr_row  = 2'(r);
        wr_col  = 2'(c);
        wr_data = 16'(d);
        start   = st;
        if (n == 0) begin
            if (we) begin
                if (sel) mb[r][c] = d & 16'hFFFF;
                else     ma[r][c] = d & 16'hFFFF;
            end
            md = 1'b0;
            if (st) n = 1;
        end else begin
            md = (n == LAST);
            n  = (n == LAST) ? 0 : n + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ma[r][c] = 0;
                mb[r][c] = 0;
            end
        n = 0;
        md = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all();
        reset = 1'b0;

        // Ramp A, identity B.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                step(1, 0, r, c, 4 * r + c + 1, 0);
                step(1, 1, r, c, (r == c) ? 1 : 0, 0);
            end
        step(0, 0, 0, 0, 0, 1);
        idle(LAST + 2);

        // Write and start in the same idle cycle.
        step(1, 0, 0, 0, 16'h7FFF, 1);
        idle(LAST + 2);

        // Writes and repeated starts during a pass must be ignored.
        step(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < LAST; k++)
            step(1, k[0], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535), 1);
        idle(3);

        // Asynchronous reset mid-stream at t = 5.
        step(0, 0, 0, 0, 0, 1);
        while (n != 7) step(0, 0, 0, 0, 0, 0);
        check_all();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        idle(LAST + 2);

        // Random 8-bit matrices through the MAC array.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    step(1, 0, r, c, $urandom_range(0, 255), 0);
                    step(1, 1, r, c, $urandom_range(0, 255), 0);
                end
            step(0, 0, 0, 0, 0, 1);
            idle(LAST + 2);
        end

        // Free-running random traffic with full-width data.
        for (int k = 0; k < 300; k++)
            step(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535),
                 ($urandom_range(0, 9) == 0));
        idle(LAST + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
